// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------+
// | Module      : uart_pkg                                             |
// | Description : Shared constants and FSM encoding for the UART       |
// |               transmit feeder (default FIFO geometry, retry        |
// |               interval, handshake state encoding).                 |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  // Default FIFO geometry; AW must equal log2(DEPTH).
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;

  // Idle cycles in WAIT_BUSY before the write strobe is repeated.
  localparam int RETRY_CYCLES  = 15;
  localparam int RETRY_W       = 4;

  // Handshake FSM encoding.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_feeder_if.sv
// +--------------------------------------------------------------------+
// | Module      : uart_tx_feeder_if                                    |
// | Description : Handshake bundle between the feeder and the UART     |
// |               transmitter. The feeder is the master (drives data,  |
// |               strobe and enable); the transmitter returns busy.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

interface uart_tx_feeder_if;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_EN;
  logic       Tx_BUSY;

  modport master (
    output Tx_DATA,
    output Tx_WR,
    output Tx_EN,
    input  Tx_BUSY
  );

  modport slave (
    input  Tx_DATA,
    input  Tx_WR,
    input  Tx_EN,
    output Tx_BUSY
  );
endinterface

`default_nettype wire

// File: rtl/uart_fifo_core.sv
// +--------------------------------------------------------------------+
// | Module      : uart_fifo_core                                       |
// | Description : Byte FIFO with registered count/full/empty. A push   |
// |               is judged against the registered full flag, so a     |
// |               push on a pop edge while full is still dropped.      |
// |               Macro UART_TX_FEEDER_OVERFLOW_EN adds a sticky       |
// |               overflow flag; otherwise overflow is tied low.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push;
  logic          pop;

  // Accept/pop decisions and next pointer/occupancy values.
  always_comb begin
    push     = wr_en && !full_q;
    pop      = rd_en && !empty_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

`ifdef UART_TX_FEEDER_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky: any push attempted while full sets it until reset.
  always_comb begin
    overflow_d = overflow_q | (wr_en & full_q);
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// +--------------------------------------------------------------------+
// | Module      : uart_tx_feeder                                       |
// | Description : Buffers bytes and hands them one at a time to the    |
// |               UART transmitter with a one-cycle write strobe,      |
// |               holding the byte until busy has risen and fallen.    |
// |               The strobe is repeated every 16 cycles while the     |
// |               transmitter fails to raise busy.                     |
// |               Macro UART_TX_FEEDER_OVERFLOW_EN enables the sticky  |
// |               overflow flag (inside uart_fifo_core).               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      wr_data,
  input  logic            wr_en,
  input  logic            tx_enable,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic            overflow,
  uart_tx_feeder_if.master tx_if
);

  tx_state_e          state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_wr_q, tx_wr_d;
  logic               tx_en_q, tx_en_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pop;
  logic [7:0]         head_data;

  uart_fifo_core #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Handshake sequencing: launch from IDLE, wait for busy to rise (with
  // periodic re-strobe), then wait for it to fall. Tx_DATA only changes
  // on a launch, so it stays stable for the whole frame.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    tx_en_d   = tx_enable;
    retry_d   = retry_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_en_q && !tx_if.Tx_BUSY) begin
          tx_data_d = head_data;
          tx_wr_d   = 1'b1;
          pop       = 1'b1;
          retry_d   = '0;
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_if.Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else if (retry_q == RETRY_W'(RETRY_CYCLES)) begin
          tx_wr_d = 1'b1;
          retry_d = '0;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_if.Tx_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transmitter-facing output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      tx_en_q   <= tx_en_d;
      retry_q   <= retry_d;
    end
  end

  assign tx_if.Tx_DATA = tx_data_q;
  assign tx_if.Tx_WR   = tx_wr_q;
  assign tx_if.Tx_EN   = tx_en_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
// +--------------------------------------------------------------------+
// | Module      : tb_uart_tx_feeder                                    |
// | Description : Directed bench for uart_tx_feeder with a simple      |
// |               transmitter model (busy for 20 cycles per strobe,    |
// |               rising combinationally with Tx_WR when acking).      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          tx_enable;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  logic          ack_en;
  int            busy_cnt = 0;

  int            errors = 0;
  int            checks = 0;

  logic [7:0]    wr_log[$];
  logic [7:0]    exp_log[$];
  int            double_wr = 0;
  logic          prev_wr = 1'b0;
  logic          exp_ovf;

  uart_tx_feeder_if tx_if ();

  uart_tx_feeder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .tx_enable (tx_enable),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_if     (tx_if)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises with the strobe and lasts 20 cycles.
  assign tx_if.Tx_BUSY = (tx_if.Tx_WR && ack_en) || (busy_cnt > 0);

  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (tx_if.Tx_WR && ack_en) busy_cnt <= 19;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Strobe monitor: log every byte strobed and any back-to-back strobe.
  always @(negedge clk) begin
    if (tx_if.Tx_WR === 1'b1) begin
      if (prev_wr) double_wr++;
      wr_log.push_back(tx_if.Tx_DATA);
    end
    prev_wr = (tx_if.Tx_WR === 1'b1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(string tag);
    int mism = 0;
    chk({tag, "_len"}, wr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i >= wr_log.size() || wr_log[i] !== exp_log[i]) mism++;
    end
    chk({tag, "_order"}, mism, 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
`ifdef UART_TX_FEEDER_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_enable = 1'b0; ack_en = 1'b1;
    steps(2);

    // Reset state
    chk("rst_full",  full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_data",  tx_if.Tx_DATA, 8'h00);
    chk("rst_wr",    tx_if.Tx_WR, 0);
    chk("rst_en",    tx_if.Tx_EN, 0);
    reset = 1'b0;

    // Basic ordering, 2-cycle push-to-strobe latency
    tx_enable = 1'b1;
    step();
    chk("tx_en_lag", tx_if.Tx_EN, 1);
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    chk("push_count", count, 1);
    chk("push_empty", empty, 0);
    chk("wr_not_yet", tx_if.Tx_WR, 0);
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    chk("first_wr",    tx_if.Tx_WR, 1);
    chk("first_data",  tx_if.Tx_DATA, 8'hA5);
    chk("pushpop_cnt", count, 1);
    steps(60);
    exp_log.delete();
    exp_log.push_back(8'hA5); exp_log.push_back(8'h3C);
    check_log("basic");
    chk("basic_empty", empty, 1);

    // Full and overflow with the transmitter disabled
    wr_log.delete();
    tx_enable = 1'b0;
    steps(2);
    chk("tx_en_off", tx_if.Tx_EN, 0);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    wr_en = 1'b0;
    chk("full_count", count, 16);
    chk("full_flag",  full, 1);
    chk("full_ovf",   overflow, exp_ovf);
    tx_enable = 1'b1;
    steps(420);
    exp_log.delete();
    for (int i = 0; i < 16; i++) exp_log.push_back(8'(8'h10 + i));
    check_log("drain");
    chk("drain_empty", empty, 1);
    chk("drain_full",  full, 0);

    // Retry: transmitter never raises busy
    ack_en = 1'b0;
    wr_log.delete();
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_data = 8'h88;
    step();
    wr_en = 1'b0;
    chk("retry_wr0",   tx_if.Tx_WR, 1);
    chk("retry_data0", tx_if.Tx_DATA, 8'h77);
    steps(15);
    chk("retry_gap",   tx_if.Tx_WR, 0);
    step();
    chk("retry_wr1",   tx_if.Tx_WR, 1);
    chk("retry_data1", tx_if.Tx_DATA, 8'h77);
    chk("retry_cnt1",  count, 1);
    steps(16);
    chk("retry_wr2",   tx_if.Tx_WR, 1);
    chk("retry_data2", tx_if.Tx_DATA, 8'h77);
    ack_en = 1'b1;

    // Hold rule: push during WAIT_DONE, data must not move
    step();
    chk("hold_wr_low", tx_if.Tx_WR, 0);
    wr_en = 1'b1; wr_data = 8'hB1;
    step();
    chk("hold_d1", tx_if.Tx_DATA, 8'h77);
    wr_data = 8'hB2;
    step();
    chk("hold_d2", tx_if.Tx_DATA, 8'h77);
    wr_data = 8'hB3;
    step();
    wr_en = 1'b0;
    chk("hold_d3",    tx_if.Tx_DATA, 8'h77);
    chk("hold_count", count, 4);
    for (int i = 0; i < 40 && tx_if.Tx_BUSY; i++) step();
    chk("busy_fall",      tx_if.Tx_BUSY, 0);
    chk("fall_wr",        tx_if.Tx_WR, 0);
    chk("fall_data",      tx_if.Tx_DATA, 8'h77);
    exp_log.delete();
    for (int i = 0; i < 3; i++) exp_log.push_back(8'h77);
    check_log("retry");
    step();
    chk("idle_gap_wr",   tx_if.Tx_WR, 0);
    chk("idle_gap_data", tx_if.Tx_DATA, 8'h77);
    step();
    chk("next_wr",    tx_if.Tx_WR, 1);
    chk("next_data",  tx_if.Tx_DATA, 8'h88);
    chk("next_count", count, 3);

    // Reset in WAIT_DONE with 3 bytes queued
    steps(3);
    chk("pre_rst_busy", tx_if.Tx_BUSY, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wr",    tx_if.Tx_WR, 0);
    chk("mid_rst_data",  tx_if.Tx_DATA, 8'h00);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_en",    tx_if.Tx_EN, 0);
    steps(2);
    reset = 1'b0;
    wr_log.delete();
    steps(30);
    chk("post_rst_strobes", wr_log.size(), 0);
    chk("post_rst_count",   count, 0);

    // Simultaneous push/pop at count=5 across pointer wrap
    tx_enable = 1'b0;
    steps(2);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hF0 + i);
      step();
    end
    wr_en = 1'b0;
    chk("wrap_full", full, 1);
    wr_log.delete();
    tx_enable = 1'b1;
    for (int i = 0; i < 400 && count != 5; i++) step();
    tx_enable = 1'b0;
    chk("reach5", count, 5);
    steps(30);
    chk("parked_count", count, 5);
    chk("parked_wr",    tx_if.Tx_WR, 0);
    exp_log.delete();
    for (int i = 0; i < 11; i++) exp_log.push_back(8'(8'hF0 + i));
    check_log("pre_wrap");
    wr_log.delete();
    tx_enable = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 8'hE0;
    step();
    wr_en = 1'b0;
    chk("simul_wr",    tx_if.Tx_WR, 1);
    chk("simul_data",  tx_if.Tx_DATA, 8'hFB);
    chk("simul_count", count, 5);
    steps(160);
    exp_log.delete();
    for (int i = 11; i < 16; i++) exp_log.push_back(8'(8'hF0 + i));
    exp_log.push_back(8'hE0);
    check_log("wrap");
    chk("wrap_empty", empty, 1);
    chk("no_double_wr", double_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
